// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch, data and shared memory port signal bundle
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_ok;
  logic [31:0]       iresp_data;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic              dreq_write;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [63:0]       dreq_wdata;
  logic              dresp_ok;
  logic [63:0]       dresp_data;

  logic              mreq_valid;
  logic [ADDR_W-1:0] mreq_addr;
  logic              mreq_write;
  logic [2:0]        mreq_size;
  logic [7:0]        mreq_strobe;
  logic [63:0]       mreq_wdata;
  logic              mresp_ok;
  logic              mresp_last;
  logic [63:0]       mresp_data;

  // The arbiter masters the shared memory port and serves both requesters.
  modport master (
    input  ireq_valid, ireq_addr,
    output iresp_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
    output dresp_ok, dresp_data,
    output mreq_valid, mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_wdata,
    input  mresp_ok, mresp_last, mresp_data
  );

  modport slave (
    output ireq_valid, ireq_addr,
    input  iresp_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
    input  dresp_ok, dresp_data,
    input  mreq_valid, mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_wdata,
    output mresp_ok, mresp_last, mresp_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data requests
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_DWAIT = 4,
  parameter int ADDR_W    = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] c_max_dwait = 4'(MAX_DWAIT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
  logic [7:0]        r_strobe;
  logic [63:0]       r_wdata;
  logic [3:0]        r_scnt;
  logic              r_iresp_ok;
  logic              r_dresp_ok;
  logic [31:0]       r_iresp_data;
  logic [63:0]       r_dresp_data;

  logic              w_idle;
  logic              w_starve;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_done;

  always_comb begin
    w_idle      = (r_state == IDLE);
    w_starve    = bus.ireq_valid && (r_scnt >= c_max_dwait);
    w_grant_d   = w_idle && bus.dreq_valid && !w_starve;
    w_grant_i   = w_idle && !w_grant_d && bus.ireq_valid;
    w_done      = !w_idle && bus.mresp_ok && bus.mresp_last;
    w_state_nxt = r_state;
    if (w_grant_d) begin
      w_state_nxt = BUSY_D;
    end else if (w_grant_i) begin
      w_state_nxt = BUSY_I;
    end else if (w_done) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched request: the shared port never sees live requester inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= 3'd0;
      r_strobe <= 8'h00;
      r_wdata  <= 64'h0;
    end else if (w_grant_d) begin
      r_addr   <= bus.dreq_addr;
      r_write  <= bus.dreq_write;
      r_size   <= bus.dreq_size;
      r_strobe <= bus.dreq_write ? bus.dreq_strobe : 8'h00;
      r_wdata  <= bus.dreq_wdata;
    end else if (w_grant_i) begin
      r_addr   <= bus.ireq_addr;
      r_write  <= 1'b0;
      r_size   <= 3'd2;
      r_strobe <= 8'h00;
      r_wdata  <= 64'h0;
    end
  end

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scnt <= 4'd0;
    end else if (!bus.ireq_valid || w_grant_i) begin
      r_scnt <= 4'd0;
    end else if (w_grant_d && (r_scnt != 4'hF)) begin
      r_scnt <= r_scnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iresp_ok   <= 1'b0;
      r_dresp_ok   <= 1'b0;
      r_iresp_data <= 32'h0;
      r_dresp_data <= 64'h0;
    end else begin
      r_iresp_ok <= w_done && (r_state == BUSY_I);
      r_dresp_ok <= w_done && (r_state == BUSY_D);
      if (w_done && (r_state == BUSY_I)) begin
        r_iresp_data <= r_addr[2] ? bus.mresp_data[63:32] : bus.mresp_data[31:0];
      end
      if (w_done && (r_state == BUSY_D)) begin
        r_dresp_data <= r_write ? 64'h0 : bus.mresp_data;
      end
    end
  end

  assign bus.mreq_valid  = (r_state != IDLE);
  assign bus.mreq_addr   = r_addr;
  assign bus.mreq_write  = r_write;
  assign bus.mreq_size   = r_size;
  assign bus.mreq_strobe = r_strobe;
  assign bus.mreq_wdata  = r_wdata;
  assign bus.iresp_ok    = r_iresp_ok;
  assign bus.iresp_data  = r_iresp_data;
  assign bus.dresp_ok    = r_dresp_ok;
  assign bus.dresp_data  = r_dresp_data;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench with requester agents and memory model
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 64;
  localparam int MAX_DWAIT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_port_arbiter #(.MAX_DWAIT(MAX_DWAIT), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } dreq_t;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    int          cyc;
  } mexp_t;

  typedef struct {
    bit          is_d;
    logic [63:0] data;
    int          cyc;
  } rexp_t;

  logic [63:0] iq[$];
  dreq_t       dq[$];
  mexp_t       mreq_q[$];
  rexp_t       resp_q[$];
  bit          gseq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Knobs owned by the main sequence.
  int          inj_pct       = 100;
  int          ok_pct        = 100;
  int          beats_min     = 1;
  int          beats_max     = 1;
  bit          mem_stall     = 0;
  bit          idle_noise    = 0;
  bit          force_data_en = 0;
  logic [63:0] force_data    = 64'h0;
  int          rst_req       = 0;

  // Reference model state: which requester owns the port, starvation count.
  int          busy       = 0;
  int          pulse      = 0;
  int          scnt       = 0;
  int          beats_left = 0;
  logic [63:0] cur_addr   = 64'h0;
  logic        cur_write  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  function automatic dreq_t rand_dreq();
    dreq_t r;
    r.addr   = 64'h1000_0000 | 64'($urandom_range(16'hFFFF));
    r.write  = 1'($urandom_range(1));
    r.size   = 3'($urandom_range(3));
    r.strobe = 8'($urandom_range(255));
    r.wdata  = {$urandom, $urandom};
    return r;
  endfunction

  function automatic dreq_t mk_dreq(input logic [63:0] a, input logic w, input logic [2:0] s,
                                    input logic [7:0] st, input logic [63:0] wd);
    dreq_t r;
    r.addr = a; r.write = w; r.size = s; r.strobe = st; r.wdata = wd;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stimulus: requester agents, memory responder and arbitration model.
  initial begin : stim
    int          rst_hold;
    int          rst_done;
    int          was_busy;
    logic [63:0] d;
    mexp_t       m;
    rexp_t       r;
    dreq_t       dr;
    rst_hold = 3;
    rst_done = 0;
    bus.ireq_valid = 0; bus.ireq_addr = '0;
    bus.dreq_valid = 0; bus.dreq_addr = '0; bus.dreq_write = 0; bus.dreq_size = 0;
    bus.dreq_strobe = 0; bus.dreq_wdata = 0;
    bus.mresp_ok = 0; bus.mresp_last = 0; bus.mresp_data = 0;
    forever begin
      @(negedge clk);
      if (rst_req != rst_done) begin
        rst_done = rst_req;
        rst_hold = 1;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        reset = 1'b1;
        busy = 0; pulse = 0; scnt = 0;
        bus.ireq_valid = 0; bus.dreq_valid = 0;
        bus.mresp_ok = 0; bus.mresp_last = 0;
      end else begin
        reset = 1'b0;
        if (pulse == 1) bus.ireq_valid = 0;
        if (!bus.ireq_valid) begin
          bus.ireq_addr = {$urandom, $urandom};
          if (iq.size() > 0 && $urandom_range(99) < inj_pct) begin
            bus.ireq_valid = 1;
            bus.ireq_addr  = iq.pop_front();
          end
        end
        if (pulse == 2) bus.dreq_valid = 0;
        if (!bus.dreq_valid) begin
          dr = rand_dreq();
          if (dq.size() > 0 && $urandom_range(99) < inj_pct) begin
            dr = dq.pop_front();
            bus.dreq_valid = 1;
          end
          bus.dreq_addr = dr.addr; bus.dreq_write = dr.write; bus.dreq_size = dr.size;
          bus.dreq_strobe = dr.strobe; bus.dreq_wdata = dr.wdata;
        end

        was_busy = busy;
        pulse = 0;
        d = {$urandom, $urandom};
        bus.mresp_ok   = 0;
        bus.mresp_last = 1'($urandom_range(1));
        if (busy != 0) begin
          if (!mem_stall && $urandom_range(99) < ok_pct) begin
            beats_left--;
            bus.mresp_ok   = 1;
            bus.mresp_last = (beats_left == 0);
            if (beats_left == 0) begin
              if (force_data_en) d = force_data;
              r.is_d = (busy == 2);
              if (busy == 1) r.data = cur_addr[2] ? {32'h0, d[63:32]} : {32'h0, d[31:0]};
              else           r.data = cur_write ? 64'h0 : d;
              r.cyc = cyc + 1;
              resp_q.push_back(r);
              pulse = busy;
              busy  = 0;
            end
          end
        end else if (idle_noise) begin
          bus.mresp_ok   = 1;
          bus.mresp_last = 1;
        end
        bus.mresp_data = d;

        if (was_busy == 0) begin
          if (bus.dreq_valid && !(bus.ireq_valid && scnt >= MAX_DWAIT)) begin
            m.addr = bus.dreq_addr; m.write = bus.dreq_write; m.size = bus.dreq_size;
            m.strobe = bus.dreq_write ? bus.dreq_strobe : 8'h00;
            m.wdata = bus.dreq_wdata; m.cyc = cyc + 1;
            mreq_q.push_back(m);
            busy = 2; cur_addr = bus.dreq_addr; cur_write = bus.dreq_write;
            scnt = bus.ireq_valid ? ((scnt < 15) ? scnt + 1 : 15) : 0;
          end else if (bus.ireq_valid) begin
            m.addr = bus.ireq_addr; m.write = 0; m.size = 3'd2; m.strobe = 8'h00;
            m.wdata = 64'h0; m.cyc = cyc + 1;
            mreq_q.push_back(m);
            busy = 1; cur_addr = bus.ireq_addr; cur_write = 0;
            scnt = 0;
          end
          if (busy != 0) beats_left = $urandom_range(beats_max, beats_min);
        end
        if (!bus.ireq_valid) scnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or a pulse.
  initial begin : monitor
    logic  prev_v;
    mexp_t m;
    rexp_t r;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      while (mreq_q.size() > 0 && mreq_q[0].cyc < cyc) begin
        fail_evt("mreq_missing_cycle", cyc, mreq_q[0].cyc);
        mreq_q.delete(0);
      end
      while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
        fail_evt("resp_missing_cycle", cyc, resp_q[0].cyc);
        resp_q.delete(0);
      end
      if (bus.mreq_valid && !prev_v) begin
        if (mreq_q.size() == 0) begin
          fail_evt("mreq_unexpected_cycle", cyc, -1);
        end else begin
          m = mreq_q.pop_front();
          chk("mreq_cycle",  64'(cyc), 64'(m.cyc));
          chk("mreq_addr",   bus.mreq_addr,   m.addr);
          chk("mreq_write",  64'(bus.mreq_write),  64'(m.write));
          chk("mreq_size",   64'(bus.mreq_size),   64'(m.size));
          chk("mreq_strobe", 64'(bus.mreq_strobe), 64'(m.strobe));
          chk("mreq_wdata",  bus.mreq_wdata,  m.wdata);
          gseq.push_back(bus.mreq_addr[31:28] != 4'h8);
        end
      end
      prev_v = bus.mreq_valid;
      if (bus.iresp_ok && bus.dresp_ok) fail_evt("both_ok", 1, 0);
      if (bus.iresp_ok || bus.dresp_ok) begin
        if (resp_q.size() == 0) begin
          fail_evt("resp_unexpected_cycle", cyc, -1);
        end else begin
          r = resp_q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(r.cyc));
          chk("resp_is_data", 64'(bus.dresp_ok), 64'(r.is_d));
          chk("resp_data", r.is_d ? bus.dresp_data : {32'h0, bus.iresp_data}, r.data);
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (!(iq.size() == 0 && dq.size() == 0 && !bus.ireq_valid && !bus.dreq_valid &&
             busy == 0 && pulse == 0 && mreq_q.size() == 0 && resp_q.size() == 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) fail_evt({name, "_timeout"}, n, limit);
  endtask

  initial begin : main
    logic [6:0] gv;
    int         n;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mreq_valid",  64'(bus.mreq_valid), 64'h0);
    chk("rst_mreq_addr",   bus.mreq_addr, 64'h0);
    chk("rst_mreq_write",  64'(bus.mreq_write), 64'h0);
    chk("rst_mreq_size",   64'(bus.mreq_size), 64'h0);
    chk("rst_mreq_strobe", 64'(bus.mreq_strobe), 64'h0);
    chk("rst_mreq_wdata",  bus.mreq_wdata, 64'h0);
    chk("rst_iresp_ok",    64'(bus.iresp_ok), 64'h0);
    chk("rst_iresp_data",  64'(bus.iresp_data), 64'h0);
    chk("rst_dresp_ok",    64'(bus.dresp_ok), 64'h0);
    chk("rst_dresp_data",  bus.dresp_data, 64'h0);
    repeat (4) @(posedge clk);
    #1;

    force_data_en = 1;
    force_data    = 64'h1111_2222_3333_4444;
    iq.push_back(64'h8000_0004);
    wait_idle("lone_fetch", 200);
    chk("lone_fetch_data", 64'(bus.iresp_data), 64'h1111_2222);

    dq.push_back(mk_dreq(64'h1000_0008, 1'b0, 3'd3, 8'hFF, 64'h0));
    dq.push_back(mk_dreq(64'h1000_0040, 1'b1, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001));
    wait_idle("store", 200);
    chk("store_dresp_data", bus.dresp_data, 64'h0);

    gseq.delete();
    iq.push_back(64'h8000_0100);
    dq.push_back(mk_dreq(64'h1000_0100, 1'b0, 3'd2, 8'h0F, 64'h0));
    wait_idle("simul", 200);
    chk("simul_grants", 64'(gseq.size()), 64'd2);
    if (gseq.size() == 2) chk("simul_order", 64'({gseq[0], gseq[1]}), 64'(2'b10));

    gseq.delete();
    for (int i = 0; i < 6; i++) dq.push_back(mk_dreq(64'h1000_0200 + 64'(i * 8), 1'b0, 3'd3, 8'h0, 64'h0));
    iq.push_back(64'h8000_0200);
    wait_idle("starve", 400);
    gv = '0;
    foreach (gseq[i]) gv = {gv[5:0], gseq[i]};
    chk("starve_grants", 64'(gseq.size()), 64'd7);
    chk("starve_order", 64'(gv), 64'(7'b1111011));

    beats_min = 3; beats_max = 3; ok_pct = 50;
    force_data = 64'h0123_4567_89AB_CDEF;
    iq.push_back(64'h8000_0010);
    wait_idle("multibeat_i", 400);
    chk("multibeat_iresp_data", 64'(bus.iresp_data), 64'h89AB_CDEF);
    dq.push_back(mk_dreq(64'h1000_0300, 1'b0, 3'd3, 8'h0, 64'h0));
    wait_idle("multibeat_d", 400);
    chk("multibeat_dresp_data", bus.dresp_data, 64'h0123_4567_89AB_CDEF);

    force_data_en = 0;
    beats_min = 1; beats_max = 3; ok_pct = 70; inj_pct = 40;
    for (int i = 0; i < 150; i++) begin
      iq.push_back(64'h8000_0000 | 64'({$urandom_range(16'h3FFF), 2'b00}));
      dq.push_back(rand_dreq());
    end
    wait_idle("random", 20000);

    inj_pct = 100; ok_pct = 100; beats_min = 1; beats_max = 1;
    mem_stall = 1;
    dq.push_back(mk_dreq(64'h1000_0400, 1'b0, 3'd3, 8'h0, 64'h0));
    n = 0;
    while (!bus.mreq_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail_evt("abort_grant_timeout", n, 50);
    repeat (2) @(posedge clk);
    #1;
    rst_req++;
    @(posedge clk); #1;
    chk("abort_mreq_valid", 64'(bus.mreq_valid), 64'h0);
    chk("abort_dresp_ok",   64'(bus.dresp_ok), 64'h0);
    chk("abort_dresp_data", bus.dresp_data, 64'h0);
    mem_stall  = 0;
    idle_noise = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_beat_dresp_ok", 64'(bus.dresp_ok), 64'h0);
      chk("late_beat_iresp_ok", 64'(bus.iresp_ok), 64'h0);
      chk("late_beat_mreq_valid", 64'(bus.mreq_valid), 64'h0);
    end
    idle_noise = 0;
    wait_idle("final", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
